// File: rtl/picobello_tile_pwr_seq_pkg.sv
// Shared types for the tile power sequencer: per-tile state encoding and
// a helper that sizes the saturating counters.
package picobello_pkg;

    localparam int TileStateW = 3;

    typedef enum logic [TileStateW-1:0] {
        TILE_OFF     = 3'd0,
        TILE_WAIT_UP = 3'd1,
        TILE_CLK_UP  = 3'd2,
        TILE_RUN     = 3'd3,
        TILE_ISO     = 3'd4,
        TILE_WAIT_DN = 3'd5,
        TILE_RST_DN  = 3'd6
    } tile_state_e;

    // Width able to hold 0..max_val, never narrower than one bit.
    function automatic int seq_cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/picobello_tile_pwr_seq_if.sv
// Per-tile control/status bundle between the power sequencer (master) and
// the tiles plus status registers (slave).
interface picobello_tile_pwr_seq_if
    import picobello_pkg::*;
#(
    parameter int NumTiles = 16
);

    logic [NumTiles-1:0]                 tile_en_i;
    logic [NumTiles-1:0]                 tile_isolated_i;
    logic [NumTiles-1:0]                 timeout_clr_i;
    logic [NumTiles-1:0]                 tile_clk_en_o;
    logic [NumTiles-1:0]                 tile_rst_no;
    logic [NumTiles-1:0]                 tile_isolate_o;
    logic [NumTiles-1:0][TileStateW-1:0] tile_state_o;
    logic [NumTiles-1:0]                 timeout_o;
    logic                                busy_o;

    modport master (
        input  tile_en_i,
        input  tile_isolated_i,
        input  timeout_clr_i,
        output tile_clk_en_o,
        output tile_rst_no,
        output tile_isolate_o,
        output tile_state_o,
        output timeout_o,
        output busy_o
    );

    modport slave (
        output tile_en_i,
        output tile_isolated_i,
        output timeout_clr_i,
        input  tile_clk_en_o,
        input  tile_rst_no,
        input  tile_isolate_o,
        input  tile_state_o,
        input  timeout_o,
        input  busy_o
    );

endinterface

// File: rtl/picobello_tile_pwr_seq_fsm.sv
// One tile's power FSM: staged clock/reset bring-up, isolation handshake
// with timeout before power-down, and a sticky timeout flag.
module picobello_tile_pwr_fsm
    import picobello_pkg::*;
#(
    parameter int RstCycles  = 8,
    parameter int IsoTimeout = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tile_en,
    input  logic        tile_isolated,
    input  logic        grant,
    input  logic        timeout_clr,
    output logic        req,
    output tile_state_e state,
    output logic        clk_en,
    output logic        rst_n,
    output logic        isolate,
    output logic        timeout
);

    localparam int CntMax = (RstCycles > IsoTimeout) ? RstCycles : IsoTimeout;
    localparam int CntW   = seq_cnt_w(CntMax);
    localparam logic [CntW-1:0] RstLast = CntW'(RstCycles - 1);
    localparam logic [CntW-1:0] IsoLast = CntW'(IsoTimeout - 1);
    localparam logic [CntW-1:0] CntSat  = CntW'(CntMax);

    tile_state_e     state_d;
    logic [CntW-1:0] cnt;
    logic            timeout_set;

    // A tile whose request vanished while waiting must not win the grant.
    assign req = ((state == TILE_WAIT_UP) && tile_en) || (state == TILE_WAIT_DN);

    always_comb begin
        state_d     = state;
        timeout_set = 1'b0;
        case (state)
            TILE_OFF:     if (tile_en) state_d = TILE_WAIT_UP;
            TILE_WAIT_UP: begin
                if (!tile_en)   state_d = TILE_OFF;
                else if (grant) state_d = TILE_CLK_UP;
            end
            TILE_CLK_UP:  if (cnt == RstLast) state_d = TILE_RUN;
            TILE_RUN:     if (!tile_en) state_d = TILE_ISO;
            TILE_ISO: begin
                if (tile_en) begin
                    state_d = TILE_RUN;
                end else if (tile_isolated) begin
                    state_d = TILE_WAIT_DN;
                end else if (cnt == IsoLast) begin
                    state_d     = TILE_WAIT_DN;
                    timeout_set = 1'b1;
                end
            end
            TILE_WAIT_DN: if (grant) state_d = TILE_RST_DN;
            TILE_RST_DN:  if (cnt == RstLast) state_d = TILE_OFF;
            default:      state_d = TILE_OFF;
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= TILE_OFF;
            cnt     <= '0;
            clk_en  <= 1'b0;
            rst_n   <= 1'b0;
            isolate <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= state_d;
            if (state_d != state) begin
                cnt <= '0;
            end else if (cnt != CntSat) begin
                cnt <= cnt + 1'b1;
            end
            clk_en  <= (state_d != TILE_OFF) && (state_d != TILE_WAIT_UP);
            rst_n   <= state_d inside {TILE_RUN, TILE_ISO, TILE_WAIT_DN};
            isolate <= state_d inside {TILE_ISO, TILE_WAIT_DN, TILE_RST_DN};
            if (timeout_set) begin
                timeout <= 1'b1;
            end else if (timeout_clr) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/picobello_tile_pwr_seq.sv
// Clock-enable/reset sequencer for the mesh tiles: per-tile FSMs sharing one
// round-robin grant that is rate-limited by a stagger counter.
module picobello_tile_pwr_seq
    import picobello_pkg::*;
#(
    parameter int NumTiles      = 16,
    parameter int RstCycles     = 8,
    parameter int StaggerCycles = 4,
    parameter int IsoTimeout    = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    picobello_tile_pwr_seq_if.master  pwr
);

    localparam int PtrW = (NumTiles > 1) ? $clog2(NumTiles) : 1;
    localparam int StW  = seq_cnt_w(StaggerCycles);

    logic [NumTiles-1:0] req;
    logic [NumTiles-1:0] gnt;
    logic [PtrW-1:0]     rr_ptr;
    logic [PtrW-1:0]     gnt_idx;
    logic                gnt_valid;
    logic [StW-1:0]      stagger;
    logic                busy;

    function automatic logic [PtrW-1:0] rr_index(input logic [PtrW-1:0] ptr, input int offset);
        int sum;
        sum = int'(ptr) + offset;
        if (sum >= NumTiles) sum = sum - NumTiles;
        return PtrW'(sum);
    endfunction

    // Search starts at the pointer and wraps, so the first hit is the RR winner.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        if (stagger == '0) begin
            for (int k = 0; k < NumTiles; k++) begin
                if (!gnt_valid && req[rr_index(rr_ptr, k)]) begin
                    gnt_valid                 = 1'b1;
                    gnt_idx                   = rr_index(rr_ptr, k);
                    gnt[rr_index(rr_ptr, k)]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr  <= '0;
            stagger <= '0;
        end else if (gnt_valid) begin
            rr_ptr  <= (gnt_idx == PtrW'(NumTiles - 1)) ? '0 : gnt_idx + 1'b1;
            stagger <= StW'(StaggerCycles - 1);
        end else if (stagger != '0) begin
            stagger <= stagger - 1'b1;
        end
    end

    for (genvar i = 0; i < NumTiles; i++) begin : g_tile
        picobello_tile_pwr_fsm #(
            .RstCycles  (RstCycles),
            .IsoTimeout (IsoTimeout)
        ) u_fsm (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .tile_en       (pwr.tile_en_i[i]),
            .tile_isolated (pwr.tile_isolated_i[i]),
            .grant         (gnt[i]),
            .timeout_clr   (pwr.timeout_clr_i[i]),
            .req           (req[i]),
            .state         (pwr.tile_state_o[i]),
            .clk_en        (pwr.tile_clk_en_o[i]),
            .rst_n         (pwr.tile_rst_no[i]),
            .isolate       (pwr.tile_isolate_o[i]),
            .timeout       (pwr.timeout_o[i])
        );
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NumTiles; i++) begin
            if ((pwr.tile_state_o[i] != TILE_OFF) && (pwr.tile_state_o[i] != TILE_RUN)) begin
                busy = 1'b1;
            end
        end
    end

    assign pwr.busy_o = busy;

endmodule

// File: tb/tb_picobello_tile_pwr_seq.sv
// Directed bench for the tile power sequencer (4 tiles, RstCycles=4,
// StaggerCycles=4, IsoTimeout=16) with hand-computed cycle expectations.
module tb_picobello_tile_pwr_seq;
    import picobello_pkg::*;

    localparam int NumTiles = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    picobello_tile_pwr_seq_if #(.NumTiles(NumTiles)) pwr ();

    picobello_tile_pwr_seq #(
        .NumTiles      (NumTiles),
        .RstCycles     (4),
        .StaggerCycles (4),
        .IsoTimeout    (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .pwr   (pwr.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        pwr.tile_en_i       = '0;
        pwr.tile_isolated_i = '0;
        pwr.timeout_clr_i   = '0;
        cycles(2);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic test_reset();
        do_reset();
        pwr.tile_en_i = 4'b0001;
        cycles(6);
        checks++;
        if (pwr.tile_clk_en_o !== 4'b0001 || pwr.tile_rst_no !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL reset_pre_run: clk_en=%b rst_n=%b expected 0001/0001",
                     pwr.tile_clk_en_o, pwr.tile_rst_no);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (pwr.tile_clk_en_o !== 4'b0000 || pwr.tile_rst_no !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_async_outputs: clk_en=%b rst_n=%b expected 0000/0000",
                     pwr.tile_clk_en_o, pwr.tile_rst_no);
        end
        checks++;
        if (pwr.tile_isolate_o !== 4'b0000 || pwr.timeout_o !== 4'b0000 ||
            pwr.busy_o !== 1'b0 || pwr.tile_state_o !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_async_status: iso=%b timeout=%b busy=%b state=%h expected 0/0/0/000",
                     pwr.tile_isolate_o, pwr.timeout_o, pwr.busy_o, pwr.tile_state_o);
        end
        cycles(1);
        rst = 1'b0;
        pwr.tile_en_i = '0;
        cycles(1);
    endtask

    task automatic test_staggered_up();
        logic [NumTiles-1:0] exp_clk;
        logic [NumTiles-1:0] exp_rst;
        do_reset();
        pwr.tile_en_i = 4'b1111;
        for (int k = 1; k <= 18; k++) begin
            cycles(1);
            exp_clk = '0;
            exp_rst = '0;
            for (int i = 0; i < NumTiles; i++) begin
                if (k >= 2 + 4 * i) exp_clk[i] = 1'b1;
                if (k >= 6 + 4 * i) exp_rst[i] = 1'b1;
            end
            checks++;
            if (pwr.tile_clk_en_o !== exp_clk || pwr.tile_rst_no !== exp_rst) begin
                errors++;
                $display("[TB] FAIL stagger_up cycle %0d: clk_en=%b rst_n=%b expected %b/%b",
                         k, pwr.tile_clk_en_o, pwr.tile_rst_no, exp_clk, exp_rst);
            end
        end
        checks++;
        if (pwr.busy_o !== 1'b0 || pwr.tile_isolate_o !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL stagger_up_idle: busy=%b iso=%b expected 0/0000",
                     pwr.busy_o, pwr.tile_isolate_o);
        end
    endtask

    task automatic test_iso_handshake();
        pwr.tile_en_i = 4'b1011;
        for (int k = 1; k <= 5; k++) begin
            cycles(1);
            checks++;
            if (pwr.tile_state_o[2] !== TILE_ISO || pwr.tile_isolate_o[2] !== 1'b1 ||
                pwr.tile_rst_no[2] !== 1'b1 || pwr.tile_clk_en_o[2] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL iso_wait cycle %0d: state=%0d iso=%b rst_n=%b clk_en=%b expected 4/1/1/1",
                         k, pwr.tile_state_o[2], pwr.tile_isolate_o[2], pwr.tile_rst_no[2], pwr.tile_clk_en_o[2]);
            end
        end
        pwr.tile_isolated_i = 4'b0100;
        cycles(1);
        checks++;
        if (pwr.tile_state_o[2] !== TILE_WAIT_DN || pwr.tile_rst_no[2] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL iso_to_wait_dn: state=%0d rst_n=%b expected 5/1",
                     pwr.tile_state_o[2], pwr.tile_rst_no[2]);
        end
        for (int k = 1; k <= 4; k++) begin
            cycles(1);
            checks++;
            if (pwr.tile_state_o[2] !== TILE_RST_DN || pwr.tile_rst_no[2] !== 1'b0 ||
                pwr.tile_clk_en_o[2] !== 1'b1 || pwr.tile_isolate_o[2] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rst_dn cycle %0d: state=%0d rst_n=%b clk_en=%b iso=%b expected 6/0/1/1",
                         k, pwr.tile_state_o[2], pwr.tile_rst_no[2], pwr.tile_clk_en_o[2], pwr.tile_isolate_o[2]);
            end
        end
        cycles(1);
        checks++;
        if (pwr.tile_state_o[2] !== TILE_OFF || pwr.tile_clk_en_o !== 4'b1011 ||
            pwr.tile_isolate_o !== 4'b0000 || pwr.timeout_o !== 4'b0000 || pwr.busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL iso_done: state=%0d clk_en=%b iso=%b timeout=%b busy=%b expected 0/1011/0000/0000/0",
                     pwr.tile_state_o[2], pwr.tile_clk_en_o, pwr.tile_isolate_o, pwr.timeout_o, pwr.busy_o);
        end
        pwr.tile_isolated_i = '0;
    endtask

    task automatic test_iso_timeout();
        pwr.tile_en_i = 4'b1001;
        cycles(16);
        checks++;
        if (pwr.tile_state_o[1] !== TILE_ISO || pwr.timeout_o !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL timeout_not_yet: state=%0d timeout=%b expected 4/0000",
                     pwr.tile_state_o[1], pwr.timeout_o);
        end
        pwr.timeout_clr_i = 4'b0010;
        cycles(1);
        pwr.timeout_clr_i = '0;
        checks++;
        if (pwr.tile_state_o[1] !== TILE_WAIT_DN || pwr.timeout_o !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL timeout_set_wins: state=%0d timeout=%b expected 5/0010",
                     pwr.tile_state_o[1], pwr.timeout_o);
        end
        cycles(1);
        checks++;
        if (pwr.tile_state_o[1] !== TILE_RST_DN || pwr.tile_rst_no[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_rst_dn: state=%0d rst_n=%b expected 6/0",
                     pwr.tile_state_o[1], pwr.tile_rst_no[1]);
        end
        cycles(4);
        checks++;
        if (pwr.tile_state_o[1] !== TILE_OFF || pwr.tile_clk_en_o !== 4'b1001 || pwr.timeout_o !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL timeout_off: state=%0d clk_en=%b timeout=%b expected 0/1001/0010",
                     pwr.tile_state_o[1], pwr.tile_clk_en_o, pwr.timeout_o);
        end
        pwr.timeout_clr_i = 4'b0010;
        cycles(1);
        pwr.timeout_clr_i = '0;
        checks++;
        if (pwr.timeout_o !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL timeout_clear: timeout=%b expected 0000", pwr.timeout_o);
        end
    endtask

    task automatic test_iso_abort();
        logic exp_iso;
        pwr.tile_en_i = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            cycles(1);
            exp_iso = (k <= 3);
            checks++;
            if (pwr.tile_isolate_o[3] !== exp_iso || pwr.tile_rst_no[3] !== 1'b1 ||
                pwr.tile_clk_en_o[3] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL iso_abort cycle %0d: iso=%b rst_n=%b clk_en=%b expected %b/1/1",
                         k, pwr.tile_isolate_o[3], pwr.tile_rst_no[3], pwr.tile_clk_en_o[3], exp_iso);
            end
            if (k == 3) pwr.tile_en_i = 4'b1001;
        end
        checks++;
        if (pwr.tile_state_o[3] !== TILE_RUN) begin
            errors++;
            $display("[TB] FAIL iso_abort_state: state=%0d expected 3", pwr.tile_state_o[3]);
        end
    endtask

    task automatic test_rr_pointer();
        do_reset();
        pwr.tile_en_i = 4'b0010;
        cycles(6);
        pwr.tile_en_i = 4'b1011;
        cycles(2);
        checks++;
        if (pwr.tile_clk_en_o !== 4'b1010 || pwr.tile_state_o[0] !== TILE_WAIT_UP) begin
            errors++;
            $display("[TB] FAIL rr_first_grant: clk_en=%b state0=%0d expected 1010/1",
                     pwr.tile_clk_en_o, pwr.tile_state_o[0]);
        end
        cycles(3);
        checks++;
        if (pwr.tile_clk_en_o !== 4'b1010 || pwr.busy_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rr_stagger_hold: clk_en=%b busy=%b expected 1010/1",
                     pwr.tile_clk_en_o, pwr.busy_o);
        end
        cycles(1);
        checks++;
        if (pwr.tile_clk_en_o !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL rr_second_grant: clk_en=%b expected 1011", pwr.tile_clk_en_o);
        end
        checks++;
        if (dut.rr_ptr !== 2'd1) begin
            errors++;
            $display("[TB] FAIL rr_pointer: ptr=%0d expected 1", dut.rr_ptr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        pwr.tile_en_i       = '0;
        pwr.tile_isolated_i = '0;
        pwr.timeout_clr_i   = '0;
        test_reset();
        test_staggered_up();
        test_iso_handshake();
        test_iso_timeout();
        test_iso_abort();
        test_rr_pointer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
